// File: rtl/centroid_div_scheduler_pkg.sv
// rtl/centroid_div_scheduler_pkg.sv - shared types and constants for the centroid divider scheduler
package centroid_div_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_STORE,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 64;
  localparam int NUM_COLORS    = 4;
  localparam int NUM_JOBS      = 8;
  localparam int X_MAX         = 1023;
  localparam int Y_MAX         = 511;
  localparam int AVG_X_W       = 10;
  localparam int AVG_Y_W       = 9;
  localparam int TMO_W         = 8;

  localparam logic [2:0] LAST_JOB = 3'(NUM_JOBS - 1);

endpackage

// File: rtl/centroid_div_scheduler_if.sv
// rtl/centroid_div_scheduler_if.sv - handshake bundle between the scheduler and the shared divider
interface centroid_div_scheduler_if
  import centroid_div_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_start;
  logic [WIDTH-1:0] div_quotient;
  logic             div_ready;

  modport master (
    output div_dividend, div_divisor, div_start,
    input  div_quotient, div_ready
  );

  modport slave (
    input  div_dividend, div_divisor, div_start,
    output div_quotient, div_ready
  );
endinterface

// File: rtl/centroid_div_scheduler_job_timeout_counter.sv
// rtl/centroid_div_scheduler_job_timeout_counter.sv - saturating per-job wait counter with clear and expire
module centroid_div_scheduler_job_timeout_counter
  import centroid_div_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {TMO_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Count 0 is the first waiting cycle, so expiry at TIMEOUT-1 gives exactly TIMEOUT wait cycles.
  assign expire = (count_q >= LAST);

endmodule

// File: rtl/centroid_div_scheduler.sv
// rtl/centroid_div_scheduler.sv - sequences the eight per-frame centroid divisions through one shared divider
module centroid_div_scheduler
  import centroid_div_scheduler_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int X_MAX   = centroid_div_scheduler_pkg::X_MAX,
  parameter int Y_MAX   = centroid_div_scheduler_pkg::Y_MAX
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  input  logic [NUM_COLORS*WIDTH-1:0]     sum_x,
  input  logic [NUM_COLORS*WIDTH-1:0]     sum_y,
  input  logic [NUM_COLORS*WIDTH-1:0]     num,
  centroid_div_scheduler_if.master        div,
  output logic [NUM_COLORS*AVG_X_W-1:0]   avg_x,
  output logic [NUM_COLORS*AVG_Y_W-1:0]   avg_y,
  output logic [NUM_COLORS-1:0]           valid,
  output logic                            busy,
  output logic                            done
);

  state_e                          state_q, state_d;
  logic [2:0]                      job_q, job_d;
  logic [NUM_COLORS*WIDTH-1:0]     sx_q, sx_d, sy_q, sy_d, nm_q, nm_d;
  logic [WIDTH-1:0]                quo_q, quo_d;
  logic [NUM_COLORS*AVG_X_W-1:0]   avg_x_q, avg_x_d;
  logic [NUM_COLORS*AVG_Y_W-1:0]   avg_y_q, avg_y_d;
  logic [NUM_COLORS-1:0]           valid_q, valid_d;
  logic                            pair_fail_q, pair_fail_d;

  logic             tmo_clear, tmo_enable, tmo_expire;
  logic [1:0]       color;
  logic             axis_y;
  logic [WIDTH-1:0] dividend, divisor;

  assign color  = job_q[2:1];
  assign axis_y = job_q[0];

  // Operands come straight from the snapshot, so they stay stable for the whole job.
  assign dividend = axis_y ? sy_q[int'(color)*WIDTH +: WIDTH] : sx_q[int'(color)*WIDTH +: WIDTH];
  assign divisor  = nm_q[int'(color)*WIDTH +: WIDTH];

  centroid_div_scheduler_job_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    nm_d        = nm_q;
    quo_d       = quo_q;
    avg_x_d     = avg_x_q;
    avg_y_d     = avg_y_q;
    valid_d     = valid_q;
    pair_fail_d = pair_fail_q;
    tmo_clear   = 1'b0;
    tmo_enable  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          sx_d        = sum_x;
          sy_d        = sum_y;
          nm_d        = num;
          job_d       = '0;
          valid_d     = '0;
          pair_fail_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (divisor == '0) begin
          pair_fail_d = 1'b1;
          state_d     = ST_NEXT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_SETTLE;
      // A ready left over from the previous job may still be high here; it is deliberately not looked at.
      ST_SETTLE: begin
        tmo_clear = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_enable = 1'b1;
        if (div.div_ready) begin
          quo_d   = div.div_quotient;
          state_d = ST_STORE;
        end else if (tmo_expire) begin
          pair_fail_d = 1'b1;
          state_d     = ST_NEXT;
        end
      end
      ST_STORE: begin
        if (axis_y) begin
          avg_y_d[int'(color)*AVG_Y_W +: AVG_Y_W] =
            (quo_q > WIDTH'(Y_MAX)) ? AVG_Y_W'(Y_MAX) : quo_q[AVG_Y_W-1:0];
        end else begin
          avg_x_d[int'(color)*AVG_X_W +: AVG_X_W] =
            (quo_q > WIDTH'(X_MAX)) ? AVG_X_W'(X_MAX) : quo_q[AVG_X_W-1:0];
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (axis_y) begin
          valid_d[color] = ~pair_fail_q;
          pair_fail_d    = 1'b0;
        end
        if (job_q == LAST_JOB) begin
          state_d = ST_DONE;
        end else begin
          job_d   = job_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      job_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      nm_q        <= '0;
      quo_q       <= '0;
      avg_x_q     <= '0;
      avg_y_q     <= '0;
      valid_q     <= '0;
      pair_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      nm_q        <= nm_d;
      quo_q       <= quo_d;
      avg_x_q     <= avg_x_d;
      avg_y_q     <= avg_y_d;
      valid_q     <= valid_d;
      pair_fail_q <= pair_fail_d;
    end
  end

  assign div.div_dividend = dividend;
  assign div.div_divisor  = divisor;
  assign div.div_start    = (state_q == ST_ISSUE);

  assign avg_x = avg_x_q;
  assign avg_y = avg_y_q;
  assign valid = valid_q;
  assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// tb/tb_centroid_div_scheduler.sv - directed vector bench for centroid_div_scheduler with a latency-configurable divider model
module tb_centroid_div_scheduler;

  localparam int W = 64;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           go    = 1'b0;
  logic [4*W-1:0] sum_x = '0;
  logic [4*W-1:0] sum_y = '0;
  logic [4*W-1:0] num   = '0;
  logic [39:0]    avg_x;
  logic [35:0]    avg_y;
  logic [3:0]     valid;
  logic           busy;
  logic           done;

  centroid_div_scheduler_if #(.WIDTH(W)) div ();

  centroid_div_scheduler #(
    .WIDTH   (W),
    .TIMEOUT (255),
    .X_MAX   (1023),
    .Y_MAX   (511)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .sum_x (sum_x),
    .sum_y (sum_y),
    .num   (num),
    .div   (div),
    .avg_x (avg_x),
    .avg_y (avg_y),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Divider model: ready drops on start, quotient is garbage until it is computed.
  int         lat         = 10;
  bit         hold_ready  = 1'b0;
  int         hang_abs    = -1;
  int         cyc         = 0;
  int         start_total = 0;
  int         done_total  = 0;
  int         start_cyc [128];
  logic [W-1:0] m_dvd = '0;
  logic [W-1:0] m_dvs = '0;
  logic [W-1:0] m_quo = '1;
  logic         m_ready = 1'b1;
  int           m_cnt = 0;
  bit           m_hang = 1'b0;

  assign div.div_ready    = m_ready;
  assign div.div_quotient = m_quo;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_total <= done_total + 1;
    if (div.div_start) begin
      if (start_total < 128) start_cyc[start_total] <= cyc;
      start_total <= start_total + 1;
      m_dvd   <= div.div_dividend;
      m_dvs   <= div.div_divisor;
      m_quo   <= '1;
      m_hang  <= (start_total == hang_abs);
      m_ready <= hold_ready;
      m_cnt   <= hold_ready ? 1 : lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_hang) begin
        m_ready <= 1'b1;
        m_quo   <= (m_dvs == '0) ? '1 : m_dvd / m_dvs;
      end
    end
  end

  typedef struct {
    logic [4*W-1:0] sx, sy, nm;
    int             lat;
    bit             hold;
    int             hang;
    bit             spam;
    logic [39:0]    ex;
    logic [35:0]    ey;
    logic [3:0]     ev;
    int             estarts;
    int             gap_idx;
    int             egap;
  } vec_t;

  vec_t vec [5];
  int   checks = 0;
  int   errs   = 0;

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int bs;
    int bd;
    int n;
    lat        = v.lat;
    hold_ready = v.hold;
    hang_abs   = (v.hang >= 0) ? start_total + v.hang : -1;
    bs         = start_total;
    bd         = done_total;
    @(negedge clk);
    sum_x = v.sx;
    sum_y = v.sy;
    num   = v.nm;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    sum_x = '1;
    sum_y = '1;
    num   = '1;
    chk("busy_after_go", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 4000) begin
      go = v.spam && (n == 3 || n == 30);
      @(negedge clk);
      n++;
    end
    go = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("avg_x", 64'(avg_x), 64'(v.ex));
    chk("avg_y", 64'(avg_y), 64'(v.ey));
    chk("valid", 64'(valid), 64'(v.ev));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_count", 64'(done_total - bd), 64'd1);
    chk("start_count", 64'(start_total - bs), 64'(v.estarts));
    chk("start_gap", 64'(start_cyc[bs + v.gap_idx + 1] - start_cyc[bs + v.gap_idx]), 64'(v.egap));
  endtask

  initial begin
    int bs;
    int n;

    vec[0].sx      = pack4(120, 80, 40, 3200);
    vec[0].sy      = pack4(60, 40, 20, 1600);
    vec[0].nm      = pack4(4, 4, 4, 32);
    vec[0].lat     = 10;
    vec[0].hold    = 1'b0;
    vec[0].hang    = -1;
    vec[0].spam    = 1'b0;
    vec[0].ex      = {10'd30, 10'd20, 10'd10, 10'd100};
    vec[0].ey      = {9'd15, 9'd10, 9'd5, 9'd50};
    vec[0].ev      = 4'b1111;
    vec[0].estarts = 8;
    vec[0].gap_idx = 0;
    vec[0].egap    = 15;

    vec[1]         = vec[0];
    vec[1].nm      = pack4(4, 0, 4, 32);
    vec[1].ev      = 4'b1011;
    vec[1].estarts = 6;
    vec[1].gap_idx = 3;
    vec[1].egap    = 19;

    vec[2]    = vec[0];
    vec[2].sx = pack4(64'h1_0000_0005, 80, 5000, 32736);
    vec[2].sy = pack4(511, 40, 600, 16384);
    vec[2].nm = pack4(1, 4, 1, 32);
    vec[2].ex = {10'd1023, 10'd20, 10'd1023, 10'd1023};
    vec[2].ey = {9'd511, 9'd10, 9'd511, 9'd511};

    vec[3]         = vec[0];
    vec[3].hang    = 3;
    vec[3].ey      = {9'd15, 9'd10, 9'd511, 9'd50};
    vec[3].ev      = 4'b1101;
    vec[3].gap_idx = 3;
    vec[3].egap    = 259;

    vec[4]      = vec[0];
    vec[4].hold = 1'b1;
    vec[4].spam = 1'b1;
    vec[4].egap = 6;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_avg_x", 64'(avg_x), 64'd0);
    chk("rst_avg_y", 64'(avg_y), 64'd0);
    chk("rst_div_start", 64'(div.div_start), 64'd0);
    chk("rst_dividend", div.div_dividend, 64'd0);
    chk("rst_divisor", div.div_divisor, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vec[i]);
    end

    // Reset while job 5 is waiting on the divider.
    lat        = 10;
    hold_ready = 1'b0;
    hang_abs   = -1;
    bs         = start_total;
    @(negedge clk);
    sum_x = vec[0].sx;
    sum_y = vec[0].sy;
    num   = vec[0].nm;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n  = 0;
    while (start_total < bs + 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_job5", 64'(start_total - bs), 64'd6);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 64'(valid), 64'b0011);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_avg_x", 64'(avg_x), 64'd0);
    chk("midrst_avg_y", 64'(avg_y), 64'd0);
    chk("midrst_div_start", 64'(div.div_start), 64'd0);
    reset = 1'b0;
    run_frame(vec[0]);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
